// File: rtl/fire_order_tx_if.sv
// Avalon-ST source bundle carrying the 64-bit order message beats.
// Beat layout matches the pcap MAC stream: byte 0 on bits [63:56].
interface fire_order_tx_if;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic [2:0]  tx_empty;

    modport master (
        output tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, tx_sop, tx_eop, tx_empty,
        output tx_ready
    );
endinterface

// File: rtl/fire_order_tx.sv
// Turns each trigger pulse into one 28-byte order message (4 beats).
// One-deep pending slot, post-message gap throttle, sent/drop counters.
module fire_order_tx #(
    parameter logic [15:0] MSG_TYPE = 16'h0A01,
    parameter int unsigned MIN_GAP  = 8,
    parameter logic [31:0] SEQ_INIT = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic [31:0] fire_security_id,
    input  logic [63:0] fire_price,
    input  logic [31:0] fire_size,
    input  logic [1:0]  fire_side,
    fire_order_tx_if.master tx,
    output logic        busy,
    output logic [31:0] sent_count,
    output logic [31:0] drop_count
);

    typedef struct packed {
        logic [31:0] id;
        logic [63:0] price;
        logic [31:0] size;
        logic [1:0]  side;
    } order_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [15:0] GAP_INIT = 16'(MIN_GAP);

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [15:0] gap_cnt;
    logic [31:0] seq;
    logic [15:0] csum;
    logic [15:0] csum_next;
    logic [63:0] beat;
    order_t      slot;
    order_t      cur;
    logic        slot_full;
    logic        fire_q;
    logic        fire_rise;
    logic        consume;
    logic        accept;
    logic [191:0] words;

    assign fire_rise = fire & ~fire_q;
    assign consume   = (state == IDLE) & slot_full;
    assign accept    = tx.tx_valid & tx.tx_ready;

    // Checksum over beats 0-2 of the message about to launch from the slot.
    always_comb begin
        words = {MSG_TYPE, seq, 16'h0000, slot.id, slot.size, slot.price};
        csum_next = '0;
        for (int i = 0; i < 12; i++) begin
            csum_next = csum_next + words[i*16 +: 16];
        end
    end

    always_comb begin
        beat = '0;
        unique case (idx)
            2'd0: beat = {MSG_TYPE, seq, 16'h0000};
            2'd1: beat = {cur.id, cur.size};
            2'd2: beat = cur.price;
            2'd3: beat = {6'b0, cur.side, 8'h00, csum, 32'h0};
            default: beat = '0;
        endcase
    end

    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = tx.tx_valid ? beat : '0;
    assign tx.tx_sop   = tx.tx_valid & (idx == 2'd0);
    assign tx.tx_eop   = tx.tx_valid & (idx == 2'd3);
    assign tx.tx_empty = tx.tx_eop ? 3'd4 : 3'd0;

    assign busy = (state != IDLE) | slot_full;

    // A trigger landing while the slot drains still gets the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q     <= 1'b0;
            slot       <= '0;
            slot_full  <= 1'b0;
            drop_count <= '0;
        end else begin
            fire_q <= fire;
            if (fire_rise) begin
                if (!slot_full || consume) begin
                    slot      <= {fire_security_id, fire_price,
                                  fire_size, fire_side};
                    slot_full <= 1'b1;
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + 32'd1;
                end
            end else if (consume) begin
                slot_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            cur        <= '0;
            csum       <= '0;
            seq        <= SEQ_INIT;
            sent_count <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (slot_full) begin
                        cur   <= slot;
                        csum  <= csum_next;
                        idx   <= 2'd0;
                        state <= SEND;
                    end
                end
                (state == SEND): begin
                    if (accept) begin
                        if (idx == 2'd3) begin
                            if (sent_count != '1) begin
                                sent_count <= sent_count + 32'd1;
                            end
                            seq <= seq + 32'd1;
                            if (MIN_GAP == 0) begin
                                state <= IDLE;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= GAP_INIT;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                (state == GAP): begin
                    if (gap_cnt <= 16'd1) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fire_order_tx.md
Name: fire_order_tx

Overview:
- Sits directly downstream of the trigger stage in the app top level and consumes its `fire` pulse.
- On each rising edge of `fire`, captures the triggering market-data fields (security_id, price, size, side) and serialises one fixed-format 28-byte order message onto a 64-bit Avalon-ST source, matching the beat format of the pcap MAC stream.
- Provides a one-deep pending slot, a minimum inter-message gap throttle, and sent/dropped counters.

Parameters:
- MSG_TYPE, 16'h0A01, message-type code placed in beat 0.
- MIN_GAP, 8, idle cycles required after each eop acceptance before the next sop may be presented (0 = back-to-back).
- SEQ_INIT, 32'd1, sequence number used for the first message after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-low.
- fire  in  1  trigger from the triggerer stage; acted on at its rising edge.
- fire_security_id  in  32  security id sampled with fire.
- fire_price  in  64  price sampled with fire.
- fire_size  in  32  size sampled with fire.
- fire_side  in  2  aggressor side sampled with fire.
- tx_data  out  64  message beat; byte 0 on bits [63:56].
- tx_valid  out  1  beat valid.
- tx_ready  in  1  sink ready.
- tx_sop  out  1  first beat.
- tx_eop  out  1  last beat.
- tx_empty  out  3  unused bytes in the eop beat.
- busy  out  1  high whenever a message is sending, the gap is counting, or the slot is full.
- sent_count  out  32  messages whose eop beat was accepted.
- drop_count  out  32  triggers discarded because the slot was full.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0; state returns to IDLE; the slot is cleared; the sequence register is set to SEQ_INIT; the fire-edge history is cleared.
  - A message in flight is abandoned with no eop.
- Edge detect: `fire_rise = fire & ~fire_q`. A level held high produces one trigger only.
- Capture: on fire_rise, the fields are registered into the pending slot (slot_full <= 1).
  - If the slot is already full and not being consumed in the same cycle, the trigger is discarded and drop_count increments.
  - If the slot is being consumed in the same cycle, the new trigger is accepted.
- Message format, 4 beats, 28 bytes:
  - Beat 0: {MSG_TYPE, seq[31:0], 16'h0000}.
  - Beat 1: {security_id, size}.
  - Beat 2: {price}.
  - Beat 3: {6'b0, side, 8'h00, csum[15:0], 32'h0}, with tx_empty = 4.
  - csum is the modulo-2^16 sum of the twelve 16-bit words of beats 0-2.
  - tx_empty is 0 on non-eop beats.
- FSM:
  - IDLE: if slot_full, load the launch registers from the slot, clear the slot, compute csum, and go to SEND with beat index 0. tx_valid rises the next cycle. Latency from fire_rise at edge N (registered fire_q) to tx_valid/tx_sop high is 2 cycles when idle and MIN_GAP satisfied.
  - SEND: present beat[idx]. Advance only on `tx_valid & tx_ready`. While tx_ready is low, tx_data/sop/eop/empty are held stable.
  - On acceptance of beat 3: sent_count increments, seq increments (wraps 2^32-1 to 0), and the FSM goes to GAP with the counter at MIN_GAP. If MIN_GAP = 0 it goes straight to IDLE.
  - GAP: decrement each cycle; go to IDLE when the counter reaches 1.
- tx_valid never deasserts mid-message once asserted. tx_sop is only high with idx 0; tx_eop only with idx 3.
- Counters saturate at 32'hFFFF_FFFF.
- Simultaneous fire_rise and slot load: the old contents launch and the new trigger fills the slot, with no drop.

Test Plan:
- Single fire: rst released, fire high at cycle 10 with id=1, price=453620000000000, size=1, side=2, tx_ready=1. Required response:
  - sop at cycle 12, 4 consecutive beats.
  - beat0 = 0A01_00000001_0000.
  - eop beat has empty=4 and the correct csum.
  - sent_count=1.
- Backpressure: tx_ready toggles 1,0,0,1 during beats 1-2 -> tx_data held constant while ready=0, no beat skipped or duplicated.
- Queue and drop: three fire rising edges 2 cycles apart with MIN_GAP=8 -> first sent, second sent with seq=2 no earlier than 8 idle cycles after the first eop, third dropped, drop_count=1.
- Level hold: fire held high for 20 cycles -> exactly one message.
- Reset mid-message: rst low during beat 2 -> tx_valid=0 immediately, counters 0; next fire sends seq=SEQ_INIT starting with sop.
- Sequence wrap: SEQ_INIT=32'hFFFF_FFFF with two fires -> seq fields FFFFFFFF then 00000000.
